// File: rtl/mult_div_unit_pkg.sv
// Shared MDU definitions: op encodings used by the main decoder and the MDU, plus FSM state type.
package mult_div_unit_pkg;

    // MDUOp encodings; anything not listed here decodes as NONE.
    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// The full result is computed on the start edge into a pending register and committed to HI/LO
// after a fixed latency, so Busy timing matches a real iterative unit.
// Optional feature: define MULT_DIV_UNIT_MADD_EN to accept MADD/MADDU (multiply-accumulate).
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    mdu_state_e        r_state;
    mdu_state_e        w_state_d;
    logic [CntW-1:0]   r_cnt;
    logic [63:0]       r_pend;
    logic              r_pend_valid;  // cleared for divide-by-zero so HI/LO are left alone
    logic              r_pend_acc;    // commit adds pending to {HI,LO} instead of replacing
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;

    logic              w_accept;
    logic              w_launch;
    logic              w_commit;
    logic [CntW-1:0]   w_cnt_load;
    logic [63:0]       w_result;
    logic              w_result_valid;
    logic              w_result_acc;

    logic [63:0]       w_prod_s;
    logic [63:0]       w_prod_u;
    logic [31:0]       w_abs_a;
    logic [31:0]       w_abs_b;
    logic [31:0]       w_div_b;
    logic [31:0]       w_uq;
    logic [31:0]       w_ur;
    logic [31:0]       w_sq;
    logic [31:0]       w_sr;
    logic [31:0]       w_divu_b;

    // Arithmetic datapath: products, and signed division done on magnitudes so that
    // 0x80000000 / -1 wraps to 0x80000000 without relying on signed-overflow behaviour.
    always_comb begin
        w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        w_prod_u = {32'd0, A} * {32'd0, B};
        w_abs_a  = A[31] ? (~A + 32'd1) : A;
        w_abs_b  = B[31] ? (~B + 32'd1) : B;
        w_div_b  = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
        w_uq     = w_abs_a / w_div_b;
        w_ur     = w_abs_a % w_div_b;
        w_sq     = (A[31] ^ B[31]) ? (~w_uq + 32'd1) : w_uq;
        w_sr     = A[31] ? (~w_ur + 32'd1) : w_ur;
        w_divu_b = (B == 32'd0) ? 32'd1 : B;
    end

    // Decode the op into a launch request, its latency and the pending result.
    always_comb begin
        w_accept       = Start && (r_state == StIdle);
        w_launch       = 1'b0;
        w_cnt_load     = CntW'(MULT_CYCLES);
        w_result       = 64'd0;
        w_result_valid = 1'b1;
        w_result_acc   = 1'b0;
        case (MDUOp)
            MDU_MULT: begin
                w_launch = w_accept;
                w_result = w_prod_s;
            end
            MDU_MULTU: begin
                w_launch = w_accept;
                w_result = w_prod_u;
            end
            MDU_DIV: begin
                w_launch       = w_accept;
                w_cnt_load     = CntW'(DIV_CYCLES);
                w_result       = {w_sr, w_sq};
                w_result_valid = (B != 32'd0);
            end
            MDU_DIVU: begin
                w_launch       = w_accept;
                w_cnt_load     = CntW'(DIV_CYCLES);
                w_result       = {A % w_divu_b, A / w_divu_b};
                w_result_valid = (B != 32'd0);
            end
`ifdef MULT_DIV_UNIT_MADD_EN
            MDU_MADD: begin
                w_launch     = w_accept;
                w_result     = w_prod_s;
                w_result_acc = 1'b1;
            end
            MDU_MADDU: begin
                w_launch     = w_accept;
                w_result     = w_prod_u;
                w_result_acc = 1'b1;
            end
`endif
            default: begin
                w_launch = 1'b0;
            end
        endcase
    end

    // FSM next state: IDLE launches on an accepted mul/div, RUN ends on the commit cycle.
    always_comb begin
        w_state_d = r_state;
        w_commit  = (r_state == StRun) && (r_cnt == CntW'(1));
        case (r_state)
            StIdle:  if (w_launch) w_state_d = StRun;
            StRun:   if (w_commit) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Latency counter and pending result, captured only on the launch edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_pend       <= 64'd0;
            r_pend_valid <= 1'b0;
            r_pend_acc   <= 1'b0;
        end else if (w_launch) begin
            r_cnt        <= w_cnt_load;
            r_pend       <= w_result;
            r_pend_valid <= w_result_valid;
            r_pend_acc   <= w_result_acc;
        end else if (r_state == StRun) begin
            r_cnt <= r_cnt - CntW'(1);
        end
    end

    // HI/LO: moves from GPRs when idle, pending result on the commit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (r_pend_valid) begin
                if (r_pend_acc) begin
                    {r_hi, r_lo} <= {r_hi, r_lo} + r_pend;
                end else begin
                    {r_hi, r_lo} <= r_pend;
                end
            end
        end else if (w_accept && (MDUOp == MDU_MTHI)) begin
            r_hi <= A;
        end else if (w_accept && (MDUOp == MDU_MTLO)) begin
            r_lo <= A;
        end
    end

    assign Busy = (r_state == StRun);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (honours MULT_DIV_UNIT_MADD_EN if defined).
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  MDUOp;
    logic        Start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_errors = 0;

    mult_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .MDUOp(MDUOp),
        .Start(Start),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issue one op at the next posedge, then count Busy cycles (bounded). If inj >= 0, a MULT
    // 3*3 is pulsed on Start during busy cycle inj and A/B are disturbed for the rest of the run.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj, output int busy_cycles);
        @(negedge clk);
        MDUOp = op; A = a; B = b; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; MDUOp = MDU_NONE;
        busy_cycles = 0;
        while (Busy && busy_cycles < 50) begin
            busy_cycles++;
            @(negedge clk);
            if (busy_cycles == inj) begin
                MDUOp = MDU_MULT; A = 32'd3; B = 32'd3; Start = 1'b1;
            end else begin
                Start = 1'b0; MDUOp = MDU_NONE;
            end
        end
        Start = 1'b0; MDUOp = MDU_NONE;
    endtask

    task automatic pulse_op(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        MDUOp = op; A = a; B = 32'd0; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; MDUOp = MDU_NONE;
    endtask

    int bc;

    initial begin
        reset = 1'b1; Start = 1'b0; MDUOp = MDU_NONE; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);

        // MULT -2 * 3
        run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, -1, bc);
        check("mult_busy", bc, 32'd5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
        run_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, -1, bc);
        check("multu_busy", bc, 32'd5);
        check("multu_hi", HI, 32'h0000_0002);
        check("multu_lo", LO, 32'hFFFF_FFFA);

        // DIV -7 / 2 -> q=-3, r=-1
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, -1, bc);
        check("div_busy", bc, 32'd10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // DIVU 7 / 2
        run_op(MDU_DIVU, 32'd7, 32'd2, -1, bc);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);

        // Overflow case
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, bc);
        check("divovf_lo", LO, 32'h8000_0000);
        check("divovf_hi", HI, 32'd0);

        // MTHI/MTLO, then divide by zero leaves HI/LO alone
        pulse_op(MDU_MTHI, 32'h11);
        check("mthi_busy", {31'd0, Busy}, 32'd0);
        check("mthi_hi", HI, 32'h11);
        pulse_op(MDU_MTLO, 32'h22);
        check("mtlo_lo", LO, 32'h22);
        check("mtlo_hi", HI, 32'h11);
        run_op(MDU_DIV, 32'd5, 32'd0, -1, bc);
        check("div0_busy", bc, 32'd10);
        check("div0_hi", HI, 32'h11);
        check("div0_lo", LO, 32'h22);

        // DIV 100/7 with a MULT pulsed mid-run and operands disturbed: q=14, r=2
        run_op(MDU_DIV, 32'd100, 32'd7, 3, bc);
        check("ign_busy", bc, 32'd10);
        check("ign_lo", LO, 32'd14);
        check("ign_hi", HI, 32'd2);
        @(negedge clk);
        check("ign_idle", {31'd0, Busy}, 32'd0);
        pulse_op(MDU_MTHI, 32'h1234);
        check("mthi2_hi", HI, 32'h1234);
        check("mthi2_busy", {31'd0, Busy}, 32'd0);
        check("mthi2_lo", LO, 32'd14);

        // NONE and undefined opcodes change nothing
        run_op(MDU_NONE, 32'hDEAD, 32'hBEEF, -1, bc);
        check("none_busy", bc, 32'd0);
        run_op(4'd15, 32'hDEAD, 32'hBEEF, -1, bc);
        check("undef_busy", bc, 32'd0);
        check("undef_hi", HI, 32'h1234);
        check("undef_lo", LO, 32'd14);

        // MADDU: {0,FFFFFFFF} + 1*1
        pulse_op(MDU_MTHI, 32'd0);
        pulse_op(MDU_MTLO, 32'hFFFF_FFFF);
        run_op(MDU_MADDU, 32'd1, 32'd1, -1, bc);
`ifdef MULT_DIV_UNIT_MADD_EN
        check("madd_busy", bc, 32'd5);
        check("madd_hi", HI, 32'd1);
        check("madd_lo", LO, 32'd0);
`else
        check("madd_busy", bc, 32'd0);
        check("madd_hi", HI, 32'd0);
        check("madd_lo", LO, 32'hFFFF_FFFF);
`endif

        // Reset during cycle 4 of a DIV aborts it
        pulse_op(MDU_MTHI, 32'h55);
        pulse_op(MDU_MTLO, 32'h66);
        @(negedge clk);
        MDUOp = MDU_DIVU; A = 32'd7; B = 32'd2; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; MDUOp = MDU_NONE;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("postrst_busy", {31'd0, Busy}, 32'd0);
        check("postrst_hi", HI, 32'd0);
        check("postrst_lo", LO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
